// File: rtl/multicycle_rils_datapath.sv
// Multicycle datapath for a small uPOWER subset: IDLE -> DECODE -> EXEC -> (MEM) -> WB.
// retire is combinational in its completion cycle; illegal and mem_err are one-cycle registered pulses.
module multicycle_rils_datapath #(
    parameter int N       = 64,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [31:0]  instr,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         retire,
    output logic         illegal,
    output logic         mem_err,
    output logic         zero_flag,
    output logic         busy,
    input  logic [4:0]   dbg_addr,
    output logic [N-1:0] dbg_data,
    output logic [2:0]   dbg_state
);
    // Handshake: instr is taken on a rising edge with instr_valid && instr_ready;
    // instr_ready is high only in IDLE, so one instruction is in flight at a time.
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [3:0] {OP_ILL, OP_ADDI, OP_ORI, OP_ANDI, OP_LD, OP_STD,
                              OP_ADD, OP_SUBF, OP_AND, OP_OR} op_t;

    state_t       state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic [N-1:0] result_q, result_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         illegal_q, illegal_d;
    logic         mem_err_q, mem_err_d;
    logic         zero_q, zero_d;
    logic [N-1:0] rf_q [32];
    logic [N-1:0] rf_d [32];

    op_t          op;
    logic [4:0]   rt, ra, rb, dest;
    logic [N-1:0] ra_val, ra0_val, rs_val, rb_val;
    logic [N-1:0] si, ui, ds, alu;

    assign rt = instr_q[25:21];
    assign ra = instr_q[20:16];
    assign rb = instr_q[15:11];
    assign ra_val  = rf_q[ra];
    assign ra0_val = (ra == 5'd0) ? '0 : ra_val;
    assign rs_val  = rf_q[rt];
    assign rb_val  = rf_q[rb];
    assign si = {{(N-16){instr_q[15]}}, instr_q[15:0]};
    assign ui = {{(N-16){1'b0}}, instr_q[15:0]};
    assign ds = {{(N-16){instr_q[15]}}, instr_q[15:2], 2'b00};

    always_comb begin
        op = OP_ILL;
        case (instr_q[31:26])
            6'd14: op = OP_ADDI;
            6'd24: op = OP_ORI;
            6'd28: op = OP_ANDI;
            6'd58: if (instr_q[1:0] == 2'b00) op = OP_LD;
            6'd62: if (instr_q[1:0] == 2'b00) op = OP_STD;
            6'd31: begin
                case (instr_q[10:1])
                    10'd266: op = OP_ADD;
                    10'd40:  op = OP_SUBF;
                    10'd28:  op = OP_AND;
                    10'd444: op = OP_OR;
                    default: op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    always_comb begin
        alu  = '0;
        dest = ra;
        case (op)
            OP_ADDI: begin alu = ra0_val + si;   dest = rt; end
            OP_ORI:  alu = rs_val | ui;
            OP_ANDI: alu = rs_val & ui;
            OP_ADD:  begin alu = ra_val + rb_val; dest = rt; end
            OP_SUBF: begin alu = rb_val - ra_val; dest = rt; end
            OP_AND:  alu = rs_val & rb_val;
            OP_OR:   alu = rs_val | rb_val;
            OP_LD:   dest = rt;
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        result_d  = result_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        mem_err_d = 1'b0;
        zero_d    = zero_q;
        rf_d      = rf_q;
        retire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == OP_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu;
                addr_d   = ra0_val + ds;
                wdata_d  = rs_val;
                cnt_d    = '0;
                state_d  = (op == OP_LD || op == OP_STD) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // An ack in the final allowed cycle still completes the access.
                if (mem_ack) begin
                    if (op == OP_LD) begin
                        result_d = mem_rdata;
                        state_d  = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    mem_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WB: begin
                retire       = 1'b1;
                rf_d[dest]   = result_q;
                if (op != OP_LD) zero_d = (result_q == '0);
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            result_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            zero_q    <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            result_q  <= result_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
            zero_q    <= zero_d;
            rf_q      <= rf_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign mem_req     = (state_q == S_MEM);
    assign mem_we      = (state_q == S_MEM) && (op == OP_STD);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign illegal     = illegal_q;
    assign mem_err     = mem_err_q;
    assign zero_flag   = zero_q;
    assign dbg_data    = rf_q[dbg_addr];
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_multicycle_rils_datapath.sv
// Randomized bench for multicycle_rils_datapath against an instruction-level reference model.
module tb_multicycle_rils_datapath;
    localparam int N       = 64;
    localparam int TIMEOUT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr;
    logic         mem_req, mem_we;
    logic [N-1:0] mem_addr, mem_wdata;
    logic         mem_ack;
    logic [N-1:0] mem_rdata;
    logic         retire, illegal, mem_err, zero_flag, busy;
    logic [4:0]   dbg_addr;
    logic [N-1:0] dbg_data;
    logic [2:0]   dbg_state;

    multicycle_rils_datapath #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .retire(retire), .illegal(illegal), .mem_err(mem_err), .zero_flag(zero_flag),
        .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_err    = 0;
    logic         chk_en   = 1'b0;
    logic [N-1:0] model_regs [32];
    logic         model_zf;
    logic [2:0]   exp_q [$];
    logic [N-1:0] last_ea, last_wd;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_d(input logic [5:0] opc, input logic [4:0] rt,
                                          input logic [4:0] ra, input logic [15:0] imm);
        return {opc, rt, ra, imm};
    endfunction

    function automatic logic [31:0] enc_ds(input logic [5:0] opc, input logic [4:0] rt,
                                           input logic [4:0] ra, input logic [13:0] dsf);
        return {opc, rt, ra, dsf, 2'b00};
    endfunction

    function automatic logic [31:0] enc_x(input logic [4:0] rt, input logic [4:0] ra,
                                          input logic [4:0] rb, input logic [9:0] xo);
        return {6'd31, rt, ra, rb, xo, 1'b0};
    endfunction

    // kind: 0 illegal, 1 alu, 2 ld, 3 std
    task automatic model_exec(input logic [31:0] iw, output int kind, output int dest,
                              output logic [N-1:0] val, output logic [N-1:0] ea,
                              output logic [N-1:0] wd);
        int           rt, ra, rb;
        longint       si, dsv;
        logic [N-1:0] ra0, uiv;
        rt   = int'(iw[25:21]);
        ra   = int'(iw[20:16]);
        rb   = int'(iw[15:11]);
        si   = longint'($signed(iw[15:0]));
        dsv  = longint'($signed(iw[15:2])) * 4;
        uiv  = N'(iw[15:0]);
        ra0  = (ra == 0) ? '0 : model_regs[ra];
        kind = 0; dest = 0; val = '0;
        ea   = ra0 + N'(dsv);
        wd   = model_regs[rt];
        case (int'(iw[31:26]))
            14: begin kind = 1; dest = rt; val = ra0 + N'(si); end
            24: begin kind = 1; dest = ra; val = model_regs[rt] | uiv; end
            28: begin kind = 1; dest = ra; val = model_regs[rt] & uiv; end
            58: if (iw[1:0] == 2'b00) begin kind = 2; dest = rt; end
            62: if (iw[1:0] == 2'b00) kind = 3;
            31: begin
                case (int'(iw[10:1]))
                    266: begin kind = 1; dest = rt; val = model_regs[ra] + model_regs[rb]; end
                    40:  begin kind = 1; dest = rt; val = model_regs[rb] - model_regs[ra]; end
                    28:  begin kind = 1; dest = ra; val = model_regs[rt] & model_regs[rb]; end
                    444: begin kind = 1; dest = ra; val = model_regs[rt] | model_regs[rb]; end
                    default: kind = 0;
                endcase
            end
            default: kind = 0;
        endcase
    endtask

    // Drives one instruction and checks every cycle against a schedule derived from its kind.
    task automatic issue(input logic [31:0] iw, input int dly, input logic [N-1:0] rd);
        int           kind, dest, done_s, ret_s, ill_s, err_s, mem_lo, mem_hi, ack_s;
        logic [N-1:0] val, ea, wd;
        model_exec(iw, kind, dest, val, ea, wd);
        last_ea = ea;
        last_wd = wd;
        ack_s = -1; ret_s = -1; ill_s = -1; err_s = -1; mem_lo = -1; mem_hi = -2; done_s = 0;
        case (kind)
            0: begin ill_s = 1; done_s = 1; exp_q.push_back(3'b010); end
            1: begin ret_s = 2; done_s = 3; exp_q.push_back(3'b001); end
            default: begin
                mem_lo = 2;
                if (dly < TIMEOUT) begin
                    ack_s  = 2 + dly;
                    mem_hi = ack_s;
                    ret_s  = (kind == 2) ? ack_s + 1 : ack_s;
                    done_s = ret_s + 1;
                    exp_q.push_back(3'b001);
                end else begin
                    mem_hi = 2 + TIMEOUT - 1;
                    err_s  = 2 + TIMEOUT;
                    done_s = err_s;
                    exp_q.push_back(3'b100);
                end
            end
        endcase
        @(negedge clk);
        chk("ready_before_accept", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = iw;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        for (int s = 0; s <= done_s; s++) begin
            @(negedge clk);
            mem_ack   = (s == ack_s);
            mem_rdata = (s == ack_s) ? rd : {$urandom, $urandom};
            #1;
            chk("busy", busy, (s < done_s));
            chk("instr_ready", instr_ready, (s >= done_s));
            chk("retire", retire, (s == ret_s));
            chk("illegal", illegal, (s == ill_s));
            chk("mem_err", mem_err, (s == err_s));
            chk("mem_req", mem_req, (s >= mem_lo && s <= mem_hi));
            if (s >= mem_lo && s <= mem_hi) begin
                chk("mem_addr", mem_addr, ea);
                chk("mem_we", mem_we, (kind == 3));
                if (kind == 3) chk("mem_wdata", mem_wdata, wd);
            end
        end
        mem_ack = 1'b0;
        if (kind == 1) begin
            model_regs[dest] = val;
            model_zf = (val == '0);
        end else if (kind == 2 && dly < TIMEOUT) begin
            model_regs[dest] = rd;
        end
    endtask

    task automatic peek(input logic [4:0] a, input logic [N-1:0] lit, input string name);
        @(negedge clk);
        #3;
        dbg_addr = a;
        #1;
        chk(name, dbg_data, lit);
        chk({name, "_model"}, model_regs[a], lit);
    endtask

    task automatic gen_random(output logic [31:0] iw, output int dly);
        logic [4:0]  rt, ra, rb;
        logic [15:0] imm;
        rt  = 5'($urandom_range(0, 7));
        ra  = 5'($urandom_range(0, 7));
        rb  = 5'($urandom_range(0, 7));
        imm = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        dly = $urandom_range(0, 5);
        case ($urandom_range(0, 9))
            0: iw = enc_d(6'd14, rt, ra, imm);
            1: iw = enc_d(6'd24, rt, ra, imm);
            2: iw = enc_d(6'd28, rt, ra, imm);
            3: iw = enc_ds(6'd58, rt, ra, imm[13:0]);
            4: iw = enc_ds(6'd62, rt, ra, imm[13:0]);
            5: iw = enc_x(rt, ra, rb, 10'd266);
            6: iw = enc_x(rt, ra, rb, 10'd40);
            7: iw = enc_x(rt, ra, rb, 10'd28);
            8: iw = enc_x(rt, ra, rb, 10'd444);
            default: begin
                case ($urandom_range(0, 3))
                    0: iw = 32'h0000_0000;
                    1: iw = enc_x(rt, ra, rb, 10'd1);
                    2: iw = {6'd58, rt, ra, imm[13:0], 2'b01};
                    default: iw = enc_d(6'd1, rt, ra, imm);
                endcase
            end
        endcase
    endtask

    // Compare process: register file and zero flag every cycle, completion pulses in order.
    always @(negedge clk) begin
        logic [2:0] code;
        #2;
        if (chk_en) begin
            chk("dbg_data", dbg_data, model_regs[dbg_addr]);
            chk("zero_flag", zero_flag, model_zf);
            code = {mem_err, illegal, retire};
            if (code != 3'b000) begin
                if (exp_q.size() == 0) chk("event_unexpected", code, 0);
                else chk("event_kind", code, exp_q.pop_front());
            end
            dbg_addr = 5'($urandom_range(0, 31));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] iw;
        int          dly;
        rst = 1'b0; instr_valid = 1'b0; instr = '0; mem_ack = 1'b0; mem_rdata = '0; dbg_addr = '0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        model_zf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_zero_flag", zero_flag, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", instr_ready, 1);
        chk("retire_after_rst", retire, 0);
        chk_en = 1'b1;

        // addi r17,r0,20
        issue(enc_d(6'd14, 5'd17, 5'd0, 16'd20), 0, '0);
        peek(5'd17, 64'd20, "addi_r17");
        chk("addi_zero_flag", zero_flag, 0);
        // addi r2,r0,16 ; ld r1,8(r2) with ack after 3 MEM cycles
        issue(enc_d(6'd14, 5'd2, 5'd0, 16'd16), 0, '0);
        issue(enc_ds(6'd58, 5'd1, 5'd2, 14'd2), 3, 64'd8);
        chk("ld_ea_literal", last_ea, 64'd24);
        peek(5'd1, 64'd8, "ld_r1");
        // addi r5,r0,5 ; std r5,8(r2)
        issue(enc_d(6'd14, 5'd5, 5'd0, 16'd5), 0, '0);
        issue(enc_ds(6'd62, 5'd5, 5'd2, 14'd2), 1, '0);
        chk("std_ea_literal", last_ea, 64'd24);
        chk("std_wdata_literal", last_wd, 64'd5);
        // ld r6,0(r2) never acknowledged
        issue(enc_ds(6'd58, 5'd6, 5'd2, 14'd0), 10, 64'hdead);
        peek(5'd6, 64'd0, "timeout_r6");
        // all-zero word
        issue(32'h0000_0000, 0, '0);
        peek(5'd17, 64'd20, "illegal_r17");
        // andi. with zero mask, subf of equal registers
        issue(enc_d(6'd28, 5'd17, 5'd9, 16'h0000), 0, '0);
        chk("andi_zero_flag", zero_flag, 1);
        issue(enc_x(5'd10, 5'd2, 5'd2, 10'd40), 0, '0);
        peek(5'd10, 64'd0, "subf_self");
        // addi with negative SI: 5 + (-7) wraps
        issue(enc_d(6'd14, 5'd11, 5'd5, 16'hfff9), 0, '0);
        peek(5'd11, 64'hffff_ffff_ffff_fffe, "addi_neg");

        for (int k = 0; k < 150; k++) begin
            gen_random(iw, dly);
            issue(iw, dly, {$urandom, $urandom});
        end

        // std r5,8(r2) interrupted by reset while in MEM
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = enc_ds(6'd62, 5'd5, 5'd2, 14'd2);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("pre_rst_mem_req", mem_req, 1);
        chk_en = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_zero_flag", zero_flag, 0);
        mem_ack = 1'b1;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        model_zf = 1'b0;
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk("midrst_reg", dbg_data, model_regs[a]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_ready", instr_ready, 1);
        chk("postrst_retire", retire, 0);
        mem_ack = 1'b0;
        chk_en = 1'b1;

        for (int k = 0; k < 40; k++) begin
            gen_random(iw, dly);
            issue(iw, dly, {$urandom, $urandom});
        end
        repeat (2) @(negedge clk);
        chk("events_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
